// File: rtl/cycle_ctrl_if.sv
// cycle_ctrl_if -- control/handshake bundle between the multi-cycle
// controller and its datapath/memory.
//   master : the controller (drives strobes, samples IR fields, flags, mem_ready)
//   slave  : datapath side (drives IR fields, flags, mem_ready; samples strobes)
// Signals:
//   opcode[3:0], cond[2:0], flags[2:0] {Z,V,N}, mem_ready  -- toward controller
//   mem_read, mem_write, addr_sel, ir_write, pc_write, reg_write, mem_to_reg,
//   alu_src, branch_taken, halted, flag_write[2:0] {Z,V,N}, state[2:0]
interface cycle_ctrl_if;
  logic [3:0] opcode;
  logic [2:0] cond;
  logic [2:0] flags;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       addr_sel;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic       alu_src;
  logic       branch_taken;
  logic       halted;
  logic [2:0] flag_write;
  logic [2:0] state;

  modport master (
    input  opcode, cond, flags, mem_ready,
    output mem_read, mem_write, addr_sel, ir_write, pc_write, reg_write,
           mem_to_reg, alu_src, branch_taken, halted, flag_write, state
  );

  modport slave (
    output opcode, cond, flags, mem_ready,
    input  mem_read, mem_write, addr_sel, ir_write, pc_write, reg_write,
           mem_to_reg, alu_src, branch_taken, halted, flag_write, state
  );
endinterface

// File: rtl/cycle_ctrl.sv
// cycle_ctrl -- multi-cycle CPU control FSM
// (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT).
// Ports:
//   clk   : system clock, state advances on the rising edge
//   rst_n : asynchronous active-low reset; forces IDLE and all-zero outputs
//   bus   : cycle_ctrl_if.master -- IR fields, flags, memory handshake and
//           every control strobe, plus the debug state code
// Strobes are decoded from the state register (and mem_ready/opcode/flags)
// so that a completing memory access can write IR/PC in the same cycle and
// reset zeroes every output without waiting for a clock edge.
module cycle_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  cycle_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state_r;
  state_t     next_state_s;
  logic       rel_r;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       addr_sel_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       reg_write_s;
  logic       mem_to_reg_s;
  logic       alu_src_s;
  logic       branch_taken_s;
  logic       halted_s;
  logic [2:0] flag_write_s;
  logic       taken_s;

  // Branch condition evaluation against flags {Z,V,N}.
  function automatic logic cond_met(input logic [2:0] c, input logic [2:0] f);
    logic z;
    logic v;
    logic n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'b000:  cond_met = !z;
      3'b001:  cond_met = z;
      3'b010:  cond_met = !z && !n;
      3'b011:  cond_met = n;
      3'b100:  cond_met = z || (!z && !n);
      3'b101:  cond_met = n || z;
      3'b110:  cond_met = v;
      3'b111:  cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  endfunction

  // Opcodes whose second ALU operand is the immediate/offset.
  function automatic logic uses_imm(input logic [3:0] op);
    uses_imm = ((op >= 4'h4) && (op <= 4'h6)) || ((op >= 4'h8) && (op <= 4'hC));
  endfunction

  // Reset-release flag: the FSM leaves IDLE only once this has been set,
  // so FETCH is reached on the second rising edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_r <= 1'b0;
    end else begin
      rel_r <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and control-strobe decode.
  always_comb begin
    next_state_s   = state_r;
    mem_read_s     = 1'b0;
    mem_write_s    = 1'b0;
    addr_sel_s     = 1'b0;
    ir_write_s     = 1'b0;
    pc_write_s     = 1'b0;
    reg_write_s    = 1'b0;
    mem_to_reg_s   = 1'b0;
    alu_src_s      = 1'b0;
    branch_taken_s = 1'b0;
    halted_s       = 1'b0;
    flag_write_s   = 3'b000;
    taken_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (rel_r) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = IDLE;
        end
      end
      FETCH: begin
        mem_read_s = 1'b1;
        if (bus.mem_ready) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          next_state_s = DECODE;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        if (bus.opcode == OP_HLT) begin
          next_state_s = HALT;
        end else begin
          next_state_s = EXEC;
        end
      end
      EXEC: begin
        alu_src_s = uses_imm(bus.opcode);
        case (bus.opcode)
          4'h0, 4'h1:             flag_write_s = 3'b111;
          4'h2, 4'h4, 4'h5, 4'h6: flag_write_s = 3'b100;
          default:                flag_write_s = 3'b000;
        endcase
        if ((bus.opcode == OP_B) || (bus.opcode == OP_BR)) begin
          taken_s        = cond_met(bus.cond, bus.flags);
          branch_taken_s = taken_s;
          pc_write_s     = taken_s;
          next_state_s   = FETCH;
        end else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
          next_state_s = MEM;
        end else begin
          next_state_s = WB;
        end
      end
      MEM: begin
        addr_sel_s = 1'b1;
        alu_src_s  = 1'b1;
        if (bus.opcode == OP_LW) begin
          mem_read_s = 1'b1;
          if (bus.mem_ready) begin
            next_state_s = WB;
          end else begin
            next_state_s = MEM;
          end
        end else if (bus.opcode == OP_SW) begin
          mem_write_s = 1'b1;
          if (bus.mem_ready) begin
            next_state_s = FETCH;
          end else begin
            next_state_s = MEM;
          end
        end else begin
          // Only loads/stores reach MEM; anything else is abandoned.
          next_state_s = FETCH;
        end
      end
      WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = (bus.opcode == OP_LW);
        next_state_s = FETCH;
      end
      HALT: begin
        halted_s     = 1'b1;
        next_state_s = HALT;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  assign bus.mem_read     = mem_read_s;
  assign bus.mem_write    = mem_write_s;
  assign bus.addr_sel     = addr_sel_s;
  assign bus.ir_write     = ir_write_s;
  assign bus.pc_write     = pc_write_s;
  assign bus.reg_write    = reg_write_s;
  assign bus.mem_to_reg   = mem_to_reg_s;
  assign bus.alu_src      = alu_src_s;
  assign bus.branch_taken = branch_taken_s;
  assign bus.halted       = halted_s;
  assign bus.flag_write   = flag_write_s;
  assign bus.state        = state_r;

endmodule
